// File: rtl/fft_stage_sequencer_if.sv
// Frame handshake and stage-select bundle between the FFT stage sequencer and its user.
// Latency: none (wires only); the sequencer registers every output it drives here.
// Backpressure: i_hold stalls the sequencer; there is no ready path back to the requester.
interface fft_stage_sequencer_if #(
  parameter int N_STAGES = 5,
  parameter int SW       = 4
);
  logic                i_start;
  logic                i_hold;
  logic [N_STAGES-1:0] o_stage_en;
  logic [SW-1:0]       o_s;
  logic                o_busy;
  logic                o_done;

  // Requester side: issues START/HOLD, observes stage outputs.
  modport master (
    output i_start,
    output i_hold,
    input  o_stage_en,
    input  o_s,
    input  o_busy,
    input  o_done
  );

  // Sequencer side.
  modport slave (
    input  i_start,
    input  i_hold,
    output o_stage_en,
    output o_s,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Steps the FFT datapath through N_STAGES butterfly stages, DWELL cycles each (one-hot + binary select).
// Latency: START accepted at edge t gives S=1 after edge t; a frame lasts N_STAGES*DWELL unstalled cycles.
// Backpressure: HOLD freezes state, counters and outputs (DONE still self-clears); optional
// back-to-back wrap without an idle gap is enabled by defining FFT_SEQ_CONTINUOUS_EN.
module fft_stage_sequencer #(
  parameter int N_STAGES = 5,
  parameter int SW       = 4,
  parameter int DWELL    = 1
) (
  input logic                 i_clk,
  input logic                 i_rst,
  fft_stage_sequencer_if.slave bus
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [DW-1:0]       r_dwell;
  logic [SW-1:0]       r_s;
  logic [N_STAGES-1:0] r_stage_en;
  logic                r_busy;
  logic                r_done;

  wire w_dwell_last = (r_dwell == DW'(DWELL - 1));
  wire w_stage_last = (r_s == SW'(N_STAGES));

  // Frame FSM: all outputs are registered here so S and STAGE_EN always move together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_dwell    <= '0;
      r_s        <= '0;
      r_stage_en <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // DONE is a single-cycle pulse even if a stall follows it.
      r_done <= 1'b0;
      if (!bus.i_hold) begin
        case (r_state)
          ST_IDLE: begin
            if (bus.i_start) begin
              r_state    <= ST_RUN;
              r_dwell    <= '0;
              r_s        <= SW'(1);
              r_stage_en <= N_STAGES'(1);
              r_busy     <= 1'b1;
            end
          end
          ST_RUN: begin
            if (!w_dwell_last) begin
              r_dwell <= r_dwell + DW'(1);
            end else begin
              r_dwell <= '0;
              if (!w_stage_last) begin
                r_s        <= r_s + SW'(1);
                r_stage_en <= r_stage_en << 1;
              end else begin
                r_done <= 1'b1;
`ifdef FFT_SEQ_CONTINUOUS_EN
                // A request on the final cycle chains the next frame with no idle gap.
                if (bus.i_start) begin
                  r_s        <= SW'(1);
                  r_stage_en <= N_STAGES'(1);
                end else begin
                  r_state    <= ST_IDLE;
                  r_s        <= '0;
                  r_stage_en <= '0;
                  r_busy     <= 1'b0;
                end
`else
                r_state    <= ST_IDLE;
                r_s        <= '0;
                r_stage_en <= '0;
                r_busy     <= 1'b0;
`endif
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_stage_en = r_stage_en;
  assign bus.o_s        = r_s;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;

endmodule
